// File: rtl/relay_frame_ctrl.sv
// relay_frame_ctrl: frame-level mod_type scheduler for the HF relay path.
//
// Sequences mod_type through OFF -> LISTEN -> (QUIET) -> MOD -> LISTEN for the
// fake-reader and fake-tag roles, detecting frame start/end from the decoded
// nibble stream and aborting QUIET/MOD after an inactivity timeout.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   role         in   3'b101 FAKE_READER, 3'b110 FAKE_TAG, anything else inactive
//   nib          in   decoded nibble
//   nib_valid    in   one-cycle strobe qualifying nib
//   tx_pending   in   peer about to transmit (drop carrier)
//   mod_type     out  registered front-end mode code
//   frame_active out  registered, high while in MOD
//   frame_len    out  registered nibble count of current/last frame, saturating
//   frame_done   out  one-cycle pulse on clean end-of-frame
//   timeout      out  one-cycle pulse on inactivity abort
module relay_frame_ctrl #(
    parameter int                   TIMEOUT_W      = 16,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 16'd40000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] role,
    input  logic [3:0] nib,
    input  logic       nib_valid,
    input  logic       tx_pending,
    output logic [2:0] mod_type,
    output logic       frame_active,
    output logic [7:0] frame_len,
    output logic       frame_done,
    output logic       timeout
);
    localparam logic [1:0] S_OFF    = 2'd0;
    localparam logic [1:0] S_LISTEN = 2'd1;
    localparam logic [1:0] S_QUIET  = 2'd2;
    localparam logic [1:0] S_MOD    = 2'd3;

    localparam logic [2:0] ROLE_READER = 3'b101;
    localparam logic [2:0] ROLE_TAG    = 3'b110;

    logic [1:0]           state_q, state_d;
    logic [2:0]           role_q;
    logic [15:0]          hist_q, hist_d;
    logic                 ph_q, ph_d;
    logic [TIMEOUT_W-1:0] timer_q, timer_d;
    logic [2:0]           mod_type_q, mod_type_d;
    logic                 frame_active_q;
    logic [7:0]           frame_len_q, frame_len_d;
    logic                 frame_done_q, frame_done_d;
    logic                 timeout_q, timeout_d;

    logic        is_reader, active, role_chg, counting, expire, is_start, frame_end;
    logic [3:0]  start_nib;
    logic [15:0] hist_shift;

    assign is_reader  = role == ROLE_READER;
    assign active     = is_reader || role == ROLE_TAG;
    assign role_chg   = role != role_q;
    assign start_nib  = is_reader ? 4'hC : 4'hF;
    assign hist_shift = {hist_q[11:0], nib};
    assign is_start   = nib_valid && nib == start_nib;
    assign counting   = state_q == S_QUIET || state_q == S_MOD;
    // A nibble arriving on the expiry cycle keeps the frame alive.
    assign expire     = counting && timer_q == TIMEOUT_CYCLES - TIMEOUT_W'(1) && !nib_valid;
    // End is only recognised on a byte boundary, i.e. when the shift leaves ph at 0.
    assign frame_end  = nib_valid && ph_q &&
                        (is_reader ? (hist_shift == 16'h0000 || hist_shift == 16'hC000)
                                   : hist_shift[7:0] == 8'h00);

    always_comb begin
        state_d      = state_q;
        hist_d       = nib_valid ? hist_shift : hist_q;
        ph_d         = nib_valid ? ~ph_q : ph_q;
        frame_len_d  = frame_len_q;
        frame_done_d = 1'b0;
        timeout_d    = 1'b0;
        if (!active) begin
            state_d = S_OFF;
        end else if (state_q == S_OFF || role_chg) begin
            state_d = S_LISTEN;
        end else if (state_q == S_MOD) begin
            if (expire) begin
                state_d   = S_LISTEN;
                timeout_d = 1'b1;
            end else if (nib_valid) begin
                frame_len_d  = frame_len_q == 8'hFF ? 8'hFF : frame_len_q + 8'd1;
                state_d      = frame_end ? S_LISTEN : S_MOD;
                frame_done_d = frame_end;
            end
        end else if (is_start) begin
            // The start nibble is the first half of the frame's first byte, so
            // the phase restarts from cleared and is then advanced by that nibble.
            state_d     = S_MOD;
            hist_d      = {12'h000, nib};
            ph_d        = 1'b1;
            frame_len_d = 8'd1;
        end else if (expire) begin
            state_d   = S_LISTEN;
            timeout_d = 1'b1;
        end else if (state_q == S_LISTEN && tx_pending) begin
            state_d = S_QUIET;
        end
        timer_d    = (nib_valid || state_d != state_q) ? '0 :
                     (counting && timer_q != '1) ? timer_q + 1'b1 : timer_q;
        mod_type_d = state_d == S_LISTEN ? (is_reader ? 3'b011 : 3'b001) :
                     state_d == S_MOD    ? (is_reader ? 3'b100 : 3'b010) : 3'b000;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_OFF;
            role_q         <= 3'b000;
            hist_q         <= 16'h0000;
            ph_q           <= 1'b0;
            timer_q        <= '0;
            mod_type_q     <= 3'b000;
            frame_active_q <= 1'b0;
            frame_len_q    <= 8'd0;
            frame_done_q   <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            role_q         <= role;
            hist_q         <= hist_d;
            ph_q           <= ph_d;
            timer_q        <= timer_d;
            mod_type_q     <= mod_type_d;
            frame_active_q <= state_d == S_MOD;
            frame_len_q    <= frame_len_d;
            frame_done_q   <= frame_done_d;
            timeout_q      <= timeout_d;
        end
    end

    assign mod_type     = mod_type_q;
    assign frame_active = frame_active_q;
    assign frame_len    = frame_len_q;
    assign frame_done   = frame_done_q;
    assign timeout      = timeout_q;
endmodule

// File: tb/tb_relay_frame_ctrl.sv
// tb_relay_frame_ctrl: directed vector bench for relay_frame_ctrl.
module tb_relay_frame_ctrl;
    localparam logic [15:0] TO = 16'd20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] role = 3'd0;
    logic [3:0] nib = 4'd0;
    logic       nib_valid = 1'b0;
    logic       tx_pending = 1'b0;
    logic [2:0] mod_type;
    logic       frame_active;
    logic [7:0] frame_len;
    logic       frame_done;
    logic       timeout;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    relay_frame_ctrl #(.TIMEOUT_W(16), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk),
        .reset(reset),
        .role(role),
        .nib(nib),
        .nib_valid(nib_valid),
        .tx_pending(tx_pending),
        .mod_type(mod_type),
        .frame_active(frame_active),
        .frame_len(frame_len),
        .frame_done(frame_done),
        .timeout(timeout)
    );

    typedef struct {
        logic [2:0] role;
        logic       nv;
        logic [3:0] nib;
        logic       txp;
        logic [2:0] mt;
        logic       act;
        logic [7:0] len;
        logic       done;
        logic       to;
    } vec_t;

    vec_t vt[35];

    function automatic vec_t mk(input logic [2:0] r, input logic v, input logic [3:0] n,
                                input logic t, input logic [2:0] m, input logic a,
                                input logic [7:0] l, input logic d, input logic o);
        vec_t x;
        x.role = r; x.nv = v; x.nib = n; x.txp = t;
        x.mt = m; x.act = a; x.len = l; x.done = d; x.to = o;
        return x;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] n);
        nib = n;
        nib_valid = 1'b1;
        tick();
        nib_valid = 1'b0;
    endtask

    task automatic chk_all(input string nm, input logic [2:0] m, input logic a,
                           input logic [7:0] l, input logic d, input logic o);
        chk({nm, ".mod_type"}, int'(mod_type), int'(m));
        chk({nm, ".frame_active"}, int'(frame_active), int'(a));
        chk({nm, ".frame_len"}, int'(frame_len), int'(l));
        chk({nm, ".frame_done"}, int'(frame_done), int'(d));
        chk({nm, ".timeout"}, int'(timeout), int'(o));
    endtask

    task automatic idle_no_timeout(input string nm, input int n);
        int early;
        early = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (timeout || frame_done) early++;
        end
        chk(nm, early, 0);
    endtask

    initial begin
        // reader bring-up and a frame ending on an aligned 0000
        vt[0]  = mk(3'd0, 0, 4'h0, 0, 3'b000, 0, 8'd0,  0, 0);
        vt[1]  = mk(3'd5, 0, 4'h0, 0, 3'b011, 0, 8'd0,  0, 0);
        vt[2]  = mk(3'd5, 1, 4'hC, 0, 3'b100, 1, 8'd1,  0, 0);
        vt[3]  = mk(3'd5, 1, 4'h0, 0, 3'b100, 1, 8'd2,  0, 0);
        vt[4]  = mk(3'd5, 1, 4'h1, 0, 3'b100, 1, 8'd3,  0, 0);
        vt[5]  = mk(3'd5, 1, 4'h2, 0, 3'b100, 1, 8'd4,  0, 0);
        vt[6]  = mk(3'd5, 1, 4'h0, 0, 3'b100, 1, 8'd5,  0, 0);
        vt[7]  = mk(3'd5, 1, 4'h0, 0, 3'b100, 1, 8'd6,  0, 0);
        vt[8]  = mk(3'd5, 1, 4'h0, 0, 3'b100, 1, 8'd7,  0, 0);
        vt[9]  = mk(3'd5, 1, 4'h0, 0, 3'b011, 0, 8'd8,  1, 0);
        vt[10] = mk(3'd5, 0, 4'h0, 0, 3'b011, 0, 8'd8,  0, 0);
        // odd-aligned 0000 (after nibble 7) must not end the frame
        vt[11] = mk(3'd5, 1, 4'hC, 0, 3'b100, 1, 8'd1,  0, 0);
        vt[12] = mk(3'd5, 1, 4'h1, 0, 3'b100, 1, 8'd2,  0, 0);
        vt[13] = mk(3'd5, 1, 4'h2, 0, 3'b100, 1, 8'd3,  0, 0);
        vt[14] = mk(3'd5, 1, 4'h0, 0, 3'b100, 1, 8'd4,  0, 0);
        vt[15] = mk(3'd5, 1, 4'h0, 0, 3'b100, 1, 8'd5,  0, 0);
        vt[16] = mk(3'd5, 1, 4'h0, 0, 3'b100, 1, 8'd6,  0, 0);
        vt[17] = mk(3'd5, 1, 4'h0, 0, 3'b100, 1, 8'd7,  0, 0);
        vt[18] = mk(3'd5, 1, 4'h3, 0, 3'b100, 1, 8'd8,  0, 0);
        vt[19] = mk(3'd5, 1, 4'h0, 0, 3'b100, 1, 8'd9,  0, 0);
        vt[20] = mk(3'd5, 1, 4'h0, 0, 3'b100, 1, 8'd10, 0, 0);
        vt[21] = mk(3'd5, 1, 4'h0, 0, 3'b100, 1, 8'd11, 0, 0);
        vt[22] = mk(3'd5, 1, 4'h0, 0, 3'b011, 0, 8'd12, 1, 0);
        // tag role: carrier drop on tx_pending, frame F300
        vt[23] = mk(3'd6, 0, 4'h0, 0, 3'b001, 0, 8'd12, 0, 0);
        vt[24] = mk(3'd6, 0, 4'h0, 1, 3'b000, 0, 8'd12, 0, 0);
        vt[25] = mk(3'd6, 1, 4'hF, 0, 3'b010, 1, 8'd1,  0, 0);
        vt[26] = mk(3'd6, 1, 4'h3, 0, 3'b010, 1, 8'd2,  0, 0);
        vt[27] = mk(3'd6, 1, 4'h0, 0, 3'b010, 1, 8'd3,  0, 0);
        vt[28] = mk(3'd6, 1, 4'h0, 0, 3'b001, 0, 8'd4,  1, 0);
        // start nibble beats tx_pending; role switches hold frame_len
        vt[29] = mk(3'd6, 1, 4'hF, 1, 3'b010, 1, 8'd1,  0, 0);
        vt[30] = mk(3'd5, 0, 4'h0, 0, 3'b011, 0, 8'd1,  0, 0);
        vt[31] = mk(3'd5, 1, 4'hC, 0, 3'b100, 1, 8'd1,  0, 0);
        vt[32] = mk(3'd6, 0, 4'h0, 0, 3'b001, 0, 8'd1,  0, 0);
        vt[33] = mk(3'd0, 0, 4'h0, 0, 3'b000, 0, 8'd1,  0, 0);
        vt[34] = mk(3'd0, 0, 4'h0, 0, 3'b000, 0, 8'd1,  0, 0);

        repeat (2) tick();
        chk_all("reset", 3'b000, 0, 8'd0, 0, 0);
        reset = 1'b1;

        foreach (vt[i]) begin
            role = vt[i].role;
            nib = vt[i].nib;
            nib_valid = vt[i].nv;
            tx_pending = vt[i].txp;
            tick();
            nib_valid = 1'b0;
            tx_pending = 1'b0;
            chk_all($sformatf("vec%0d", i), vt[i].mt, vt[i].act, vt[i].len, vt[i].done, vt[i].to);
        end

        // timeout out of MOD
        role = 3'd5;
        tick();
        send(4'hC);
        chk("mod_to.enter", int'(mod_type), 3'b100);
        idle_no_timeout("mod_to.early", int'(TO) - 1);
        tick();
        chk_all("mod_to.fire", 3'b011, 0, 8'd1, 0, 1);
        tick();
        chk("mod_to.pulse_end", int'(timeout), 0);

        // timeout out of QUIET
        tx_pending = 1'b1;
        tick();
        tx_pending = 1'b0;
        chk("quiet_to.enter", int'(mod_type), 3'b000);
        idle_no_timeout("quiet_to.early", int'(TO) - 1);
        tick();
        chk_all("quiet_to.fire", 3'b011, 0, 8'd1, 0, 1);
        tick();
        chk("quiet_to.pulse_end", int'(timeout), 0);

        // nibble on the expiry cycle defers the timeout
        send(4'hC);
        repeat (int'(TO) - 1) tick();
        send(4'h1);
        chk_all("exp_nib", 3'b100, 1, 8'd2, 0, 0);
        idle_no_timeout("exp_nib.early", int'(TO) - 1);
        tick();
        chk_all("exp_nib.fire", 3'b011, 0, 8'd2, 0, 1);

        // 300-nibble frame saturates frame_len
        send(4'hC);
        repeat (299) send(4'h1);
        chk("long.len", int'(frame_len), 255);
        chk("long.mod", int'(mod_type), 3'b100);
        repeat (3) send(4'h0);
        chk("long.not_done", int'(frame_done), 0);
        send(4'h0);
        chk_all("long.end", 3'b011, 0, 8'd255, 1, 0);

        // asynchronous reset mid-frame
        send(4'hC);
        send(4'h1);
        #2 reset = 1'b0;
        #1;
        chk_all("async_rst", 3'b000, 0, 8'd0, 0, 0);
        tick();
        reset = 1'b1;
        tick();
        chk_all("rst_release", 3'b011, 0, 8'd0, 0, 0);
        tick();
        chk_all("rst_release2", 3'b011, 0, 8'd0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
